// File: rtl/box_physics_pkg.sv
// Shared widths, FSM encoding and reset-value helpers for the N-box physics engine.
package box_physics_pkg;

    localparam int X_W  = 10;
    localparam int Y_W  = 9;
    localparam int V_W  = 8;
    localparam int CD_W = 4;
    // Signed working width for position + velocity before clamping
    localparam int C_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_COLLIDE,
        ST_DONE
    } state_t;

    function automatic logic [X_W-1:0] init_x(input int i);
        return X_W'(20 + 60 * i);
    endfunction

    function automatic logic [Y_W-1:0] init_y(input int i);
        return (i % 2 == 0) ? Y_W'(20) : Y_W'(60);
    endfunction

    function automatic logic signed [V_W-1:0] init_vx(input int i);
        return (i % 2 == 0) ? V_W'(2) : V_W'(-2);
    endfunction

    function automatic logic signed [V_W-1:0] init_vy(input int i);
        return ((i % 4) < 2) ? V_W'(-1) : V_W'(1);
    endfunction

    // Lexicographic index of unordered pair (i,j), i<j, among n boxes
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * (2 * n - i - 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/box_physics_n_pair_sequencer.sv
// Walks all unordered box pairs (0,1),(0,2)..(N-2,N-1), one per step.
module pair_sequencer
    import box_physics_pkg::*;
#(
    parameter int N      = 4,
    parameter int IDX_W  = 2,
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    output logic [IDX_W-1:0]  pair_i,
    output logic [IDX_W-1:0]  pair_j,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_i <= '0;
            pair_j <= IDX_W'(1);
        end else if (start) begin
            pair_i <= '0;
            pair_j <= IDX_W'(1);
        end else if (step && !last) begin
            if (pair_j == IDX_W'(N - 1)) begin
                pair_i <= pair_i + 1'b1;
                pair_j <= pair_i + IDX_W'(2);
            end else begin
                pair_j <= pair_j + 1'b1;
            end
        end
    end

    assign last = (pair_i == IDX_W'(N - 2)) && (pair_j == IDX_W'(N - 1));
    assign slot = SLOT_W'(pair_idx(int'(pair_i), int'(pair_j), N));

endmodule

// File: rtl/box_physics_n.sv
// N-box physics engine: per-frame serial move with wall reflection, then
// serial pairwise collision with cooldown, hit counting and colour advance.
module box_physics_n
    import box_physics_pkg::*;
#(
    parameter int N         = 4,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BOX_W     = 48,
    parameter int BOX_H     = 32,
    parameter int CD_FRAMES = 5,
    parameter int HIT_W     = 8,
    parameter int COLOR_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   pause,
    output logic [N*X_W-1:0]       pos_x,
    output logic [N*Y_W-1:0]       pos_y,
    output logic [N*V_W-1:0]       vel_x,
    output logic [N*V_W-1:0]       vel_y,
    output logic [N*HIT_W-1:0]     hits,
    output logic [N*COLOR_W-1:0]   color_idx,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int P      = N * (N - 1) / 2;
    localparam int IDX_W  = (N > 2) ? $clog2(N) : 1;
    localparam int SLOT_W = (P > 1) ? $clog2(P) : 1;

    localparam logic signed [C_W-1:0] MAX_X = C_W'(SCREEN_W - BOX_W);
    localparam logic signed [C_W-1:0] MAX_Y = C_W'(SCREEN_H - BOX_H);
    localparam logic [C_W-1:0]        BW_C  = C_W'(BOX_W);
    localparam logic [C_W-1:0]        BH_C  = C_W'(BOX_H);

    function automatic logic signed [V_W-1:0] vabs(input logic signed [V_W-1:0] v);
        return v[V_W-1] ? -v : v;
    endfunction

    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] h);
        return (&h) ? h : h + 1'b1;
    endfunction

    state_t state, state_nxt;
    logic [IDX_W-1:0] box_cnt;

    logic [X_W-1:0]          px      [N];
    logic [Y_W-1:0]          py      [N];
    logic signed [V_W-1:0]   vx      [N];
    logic signed [V_W-1:0]   vy      [N];
    logic [HIT_W-1:0]        hit_cnt [N];
    logic [COLOR_W-1:0]      col     [N];
    logic [CD_W-1:0]         cd      [P];

    logic                    tick_go;
    logic [IDX_W-1:0]        seq_i, seq_j;
    logic [SLOT_W-1:0]       seq_slot;
    logic                    seq_last;

    assign tick_go = frame_tick && !pause && (state == ST_IDLE);

    pair_sequencer #(
        .N      (N),
        .IDX_W  (IDX_W),
        .SLOT_W (SLOT_W)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (tick_go),
        .step   (state == ST_COLLIDE),
        .pair_i (seq_i),
        .pair_j (seq_j),
        .slot   (seq_slot),
        .last   (seq_last)
    );

    // Move stage: candidate position/velocity for the box selected by box_cnt
    logic [X_W-1:0]        cur_px, mv_px;
    logic [Y_W-1:0]        cur_py, mv_py;
    logic signed [V_W-1:0] cur_vx, cur_vy, mv_vx, mv_vy;
    logic signed [C_W-1:0] nx, ny;

    always_comb begin
        cur_px = px[box_cnt];
        cur_py = py[box_cnt];
        cur_vx = vx[box_cnt];
        cur_vy = vy[box_cnt];
        nx = {{(C_W-X_W){1'b0}}, cur_px} + {{(C_W-V_W){cur_vx[V_W-1]}}, cur_vx};
        ny = {{(C_W-Y_W){1'b0}}, cur_py} + {{(C_W-V_W){cur_vy[V_W-1]}}, cur_vy};

        if (nx < 0) begin
            mv_px = '0;
            mv_vx = vabs(cur_vx);
        end else if (nx > MAX_X) begin
            mv_px = MAX_X[X_W-1:0];
            mv_vx = -vabs(cur_vx);
        end else begin
            mv_px = nx[X_W-1:0];
            mv_vx = cur_vx;
        end

        if (ny < 0) begin
            mv_py = '0;
            mv_vy = vabs(cur_vy);
        end else if (ny > MAX_Y) begin
            mv_py = MAX_Y[Y_W-1:0];
            mv_vy = -vabs(cur_vy);
        end else begin
            mv_py = ny[Y_W-1:0];
            mv_vy = cur_vy;
        end
    end

    // Collide stage: overlap test on the pair currently presented by the sequencer
    logic [C_W-1:0] xi, xj, yi, yj;
    logic           overlap, hit;

    always_comb begin
        xi = C_W'(px[seq_i]);
        xj = C_W'(px[seq_j]);
        yi = C_W'(py[seq_i]);
        yj = C_W'(py[seq_j]);
        overlap = (xi < xj + BW_C) && (xj < xi + BW_C) &&
                  (yi < yj + BH_C) && (yj < yi + BH_C);
        hit = (state == ST_COLLIDE) && overlap && (cd[seq_slot] == '0);
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_tick && !pause) state_nxt = ST_MOVE;
            end
            ST_MOVE: begin
                if (box_cnt == IDX_W'(N - 1)) state_nxt = ST_COLLIDE;
            end
            ST_COLLIDE: begin
                if (seq_last) state_nxt = ST_DONE;
            end
            default: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            box_cnt <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < N; i++) begin
                px[i]      <= init_x(i);
                py[i]      <= init_y(i);
                vx[i]      <= init_vx(i);
                vy[i]      <= init_vy(i);
                hit_cnt[i] <= '0;
                col[i]     <= COLOR_W'(i);
            end
            for (int k = 0; k < P; k++) cd[k] <= '0;
        end else begin
            state <= state_nxt;
            if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
            case (state)
                ST_IDLE: box_cnt <= '0;
                ST_MOVE: begin
                    px[box_cnt] <= mv_px;
                    py[box_cnt] <= mv_py;
                    vx[box_cnt] <= mv_vx;
                    vy[box_cnt] <= mv_vy;
                    box_cnt     <= box_cnt + 1'b1;
                    if (box_cnt == '0) begin
                        for (int k = 0; k < P; k++)
                            if (cd[k] != '0) cd[k] <= cd[k] - 1'b1;
                    end
                end
                ST_COLLIDE: begin
                    if (hit) begin
                        vx[seq_i]      <= -vx[seq_i];
                        vy[seq_i]      <= -vy[seq_i];
                        vx[seq_j]      <= -vx[seq_j];
                        vy[seq_j]      <= -vy[seq_j];
                        hit_cnt[seq_i] <= sat_inc(hit_cnt[seq_i]);
                        hit_cnt[seq_j] <= sat_inc(hit_cnt[seq_j]);
                        col[seq_i]     <= col[seq_i] + 1'b1;
                        col[seq_j]     <= col[seq_j] + 1'b1;
                        cd[seq_slot]   <= CD_W'(CD_FRAMES);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign pos_x[g*X_W +: X_W]             = px[g];
        assign pos_y[g*Y_W +: Y_W]             = py[g];
        assign vel_x[g*V_W +: V_W]             = vx[g];
        assign vel_y[g*V_W +: V_W]             = vy[g];
        assign hits[g*HIT_W +: HIT_W]          = hit_cnt[g];
        assign color_idx[g*COLOR_W +: COLOR_W] = col[g];
    end

endmodule

// File: tb/tb_box_physics_n.sv
// Scoreboard bench: three engine configurations checked against a behavioural frame model.
module tb_box_physics_n;

    typedef logic [5:0][127:0] snap_t;

    localparam int C_N  [3] = '{4, 4, 8};
    localparam int C_SW [3] = '{640, 260, 640};
    localparam int C_SH [3] = '{480, 110, 200};
    localparam int C_CD [3] = '{5, 2, 3};
    localparam int C_HW [3] = '{8, 3, 8};
    localparam int C_CW [3] = '{3, 2, 3};
    localparam int BW = 48;
    localparam int BH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_a = 1'b0, tick_b = 1'b0, tick_c = 1'b0;
    logic pause_a = 1'b0, pause_b = 1'b0, pause_c = 1'b0;

    logic [39:0] px_a;  logic [35:0] py_a;  logic [31:0] vx_a, vy_a, hits_a; logic [11:0] col_a;
    logic [39:0] px_b;  logic [35:0] py_b;  logic [31:0] vx_b, vy_b; logic [11:0] hits_b; logic [7:0] col_b;
    logic [79:0] px_c;  logic [71:0] py_c;  logic [63:0] vx_c, vy_c, hits_c; logic [23:0] col_c;
    logic busy_a, fd_a, ovr_a, busy_b, fd_b, ovr_b, busy_c, fd_c, ovr_c;

    int n_checks = 0;
    int n_fail   = 0;

    int mpx [3][8], mpy [3][8], mvx [3][8], mvy [3][8], mhit [3][8], mcol [3][8];
    int mcd [3][28];
    snap_t sb_a[$], sb_b[$], sb_c[$];
    string fname [6] = '{"pos_x", "pos_y", "vel_x", "vel_y", "hits", "color_idx"};

    always #5 clk = ~clk;

    box_physics_n #(.N(4), .SCREEN_W(640), .SCREEN_H(480), .BOX_W(48), .BOX_H(32),
                    .CD_FRAMES(5), .HIT_W(8), .COLOR_W(3)) dut_a (
        .clk(clk), .rst(rst), .frame_tick(tick_a), .pause(pause_a),
        .pos_x(px_a), .pos_y(py_a), .vel_x(vx_a), .vel_y(vy_a), .hits(hits_a),
        .color_idx(col_a), .busy(busy_a), .frame_done(fd_a), .overrun(ovr_a));

    box_physics_n #(.N(4), .SCREEN_W(260), .SCREEN_H(110), .BOX_W(48), .BOX_H(32),
                    .CD_FRAMES(2), .HIT_W(3), .COLOR_W(2)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(tick_b), .pause(pause_b),
        .pos_x(px_b), .pos_y(py_b), .vel_x(vx_b), .vel_y(vy_b), .hits(hits_b),
        .color_idx(col_b), .busy(busy_b), .frame_done(fd_b), .overrun(ovr_b));

    box_physics_n #(.N(8), .SCREEN_W(640), .SCREEN_H(200), .BOX_W(48), .BOX_H(32),
                    .CD_FRAMES(3), .HIT_W(8), .COLOR_W(3)) dut_c (
        .clk(clk), .rst(rst), .frame_tick(tick_c), .pause(pause_c),
        .pos_x(px_c), .pos_y(py_c), .vel_x(vx_c), .vel_y(vy_c), .hits(hits_c),
        .color_idx(col_c), .busy(busy_c), .frame_done(fd_c), .overrun(ovr_c));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset(input int d);
        for (int i = 0; i < 8; i++) begin
            mpx[d][i]  = 20 + 60 * i;
            mpy[d][i]  = (i % 2 == 1) ? 60 : 20;
            mvx[d][i]  = (i % 2 == 1) ? -2 : 2;
            mvy[d][i]  = ((i % 4) <= 1) ? -1 : 1;
            mhit[d][i] = 0;
            mcol[d][i] = i % (1 << C_CW[d]);
        end
        for (int k = 0; k < 28; k++) mcd[d][k] = 0;
    endtask

    task automatic reflect(input int p, input int v, input int lim, output int np, output int nv);
        int mag;
        mag = (v < 0) ? -v : v;
        np = p + v;
        nv = v;
        if (np < 0) begin
            np = 0;
            nv = mag;
        end else if (np > lim) begin
            np = lim;
            nv = -mag;
        end
    endtask

    task automatic model_frame(input int d);
        int n, s, np, nv, top;
        n = C_N[d];
        top = (1 << C_HW[d]) - 1;
        for (int k = 0; k < 28; k++) if (mcd[d][k] > 0) mcd[d][k]--;
        for (int i = 0; i < n; i++) begin
            reflect(mpx[d][i], mvx[d][i], C_SW[d] - BW, np, nv);
            mpx[d][i] = np; mvx[d][i] = nv;
            reflect(mpy[d][i], mvy[d][i], C_SH[d] - BH, np, nv);
            mpy[d][i] = np; mvy[d][i] = nv;
        end
        s = 0;
        for (int i = 0; i < n - 1; i++) begin
            for (int j = i + 1; j < n; j++) begin
                if (mpx[d][i] < mpx[d][j] + BW && mpx[d][j] < mpx[d][i] + BW &&
                    mpy[d][i] < mpy[d][j] + BH && mpy[d][j] < mpy[d][i] + BH &&
                    mcd[d][s] == 0) begin
                    mvx[d][i] = -mvx[d][i]; mvy[d][i] = -mvy[d][i];
                    mvx[d][j] = -mvx[d][j]; mvy[d][j] = -mvy[d][j];
                    if (mhit[d][i] < top) mhit[d][i]++;
                    if (mhit[d][j] < top) mhit[d][j]++;
                    mcol[d][i] = (mcol[d][i] + 1) % (1 << C_CW[d]);
                    mcol[d][j] = (mcol[d][j] + 1) % (1 << C_CW[d]);
                    mcd[d][s] = C_CD[d];
                end
                s++;
            end
        end
    endtask

    function automatic logic [127:0] fld(input int v, input int w);
        return 128'(v & ((1 << w) - 1));
    endfunction

    function automatic snap_t model_snap(input int d);
        snap_t s;
        s = '0;
        for (int i = 0; i < C_N[d]; i++) begin
            s[0] = s[0] | (fld(mpx[d][i], 10) << (i * 10));
            s[1] = s[1] | (fld(mpy[d][i], 9) << (i * 9));
            s[2] = s[2] | (fld(mvx[d][i], 8) << (i * 8));
            s[3] = s[3] | (fld(mvy[d][i], 8) << (i * 8));
            s[4] = s[4] | (fld(mhit[d][i], C_HW[d]) << (i * C_HW[d]));
            s[5] = s[5] | (fld(mcol[d][i], C_CW[d]) << (i * C_CW[d]));
        end
        return s;
    endfunction

    // ---------------- DUT access ----------------
    function automatic snap_t obs(input int d);
        snap_t s;
        s = '0;
        case (d)
            0: begin s[0] = 128'(px_a); s[1] = 128'(py_a); s[2] = 128'(vx_a);
                     s[3] = 128'(vy_a); s[4] = 128'(hits_a); s[5] = 128'(col_a); end
            1: begin s[0] = 128'(px_b); s[1] = 128'(py_b); s[2] = 128'(vx_b);
                     s[3] = 128'(vy_b); s[4] = 128'(hits_b); s[5] = 128'(col_b); end
            default: begin s[0] = 128'(px_c); s[1] = 128'(py_c); s[2] = 128'(vx_c);
                     s[3] = 128'(vy_c); s[4] = 128'(hits_c); s[5] = 128'(col_c); end
        endcase
        return s;
    endfunction

    function automatic logic busy_of(input int d);
        case (d) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction

    function automatic logic fd_of(input int d);
        case (d) 0: return fd_a; 1: return fd_b; default: return fd_c; endcase
    endfunction

    task automatic set_tick(input int d, input logic v);
        case (d) 0: tick_a = v; 1: tick_b = v; default: tick_c = v; endcase
    endtask

    task automatic set_pause(input int d, input logic v);
        case (d) 0: pause_a = v; 1: pause_b = v; default: pause_c = v; endcase
    endtask

    task automatic sb_push(input int d, input snap_t s);
        case (d) 0: sb_a.push_back(s); 1: sb_b.push_back(s); default: sb_c.push_back(s); endcase
    endtask

    function automatic int sb_size(input int d);
        case (d) 0: return sb_a.size(); 1: return sb_b.size(); default: return sb_c.size(); endcase
    endfunction

    task automatic sb_compare(input int d);
        snap_t e, o;
        check_eq("sb_pending", 128'(sb_size(d) != 0), 128'(1));
        if (sb_size(d) != 0) begin
            case (d)
                0: e = sb_a.pop_front();
                1: e = sb_b.pop_front();
                default: e = sb_c.pop_front();
            endcase
            o = obs(d);
            for (int f = 0; f < 6; f++) check_eq(fname[f], o[f], e[f]);
        end
    endtask

    always @(negedge clk) begin
        if (fd_a) sb_compare(0);
        if (fd_b) sb_compare(1);
        if (fd_c) sb_compare(2);
    end

    // ---------------- stimulus ----------------
    task automatic run_frame(input int d);
        @(negedge clk);
        model_frame(d);
        sb_push(d, model_snap(d));
        set_tick(d, 1'b1);
        @(negedge clk);
        set_tick(d, 1'b0);
        for (int k = 0; k < 80 && busy_of(d); k++) @(negedge clk);
        check_eq("frame_ends", 128'(busy_of(d)), 128'(0));
    endtask

    task automatic timing_frame(input int d, input int lat, input bit retick);
        @(negedge clk);
        model_frame(d);
        sb_push(d, model_snap(d));
        set_tick(d, 1'b1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            set_tick(d, retick && (k == 3));
            if (k == 2) set_pause(d, 1'b1);
            if (k == 6) set_pause(d, 1'b0);
            check_eq("busy_window", 128'(busy_of(d)), 128'(k <= lat));
            check_eq("frame_done_time", 128'(fd_of(d)), 128'(k == lat));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_d, cnt_m;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) model_reset(d);
        @(negedge clk);

        check_eq("rst_pos_x", 128'(px_a), 128'({10'd200, 10'd140, 10'd80, 10'd20}));
        check_eq("rst_pos_y", 128'(py_a), 128'({9'd60, 9'd20, 9'd60, 9'd20}));
        check_eq("rst_vel_x", 128'(vx_a), 128'({8'hFE, 8'h02, 8'hFE, 8'h02}));
        check_eq("rst_vel_y", 128'(vy_a), 128'({8'h01, 8'h01, 8'hFF, 8'hFF}));
        check_eq("rst_hits", 128'(hits_a), 128'(0));
        check_eq("rst_color", 128'(col_a), 128'({3'd3, 3'd2, 3'd1, 3'd0}));
        check_eq("rst_ctrl_a", 128'({busy_a, fd_a, ovr_a}), 128'(0));
        check_eq("rst_ctrl_b", 128'({busy_b, fd_b, ovr_b}), 128'(0));
        check_eq("rst_ctrl_c", 128'({busy_c, fd_c, ovr_c}), 128'(0));
        for (int d = 1; d < 3; d++) begin
            snap_t o, e;
            o = obs(d);
            e = model_snap(d);
            for (int f = 0; f < 6; f++) check_eq({"rst_", fname[f]}, o[f], e[f]);
        end

        timing_frame(0, 11, 1'b0);

        @(negedge clk);
        pause_a = 1'b1;
        tick_a  = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("pause_busy", 128'(busy_a), 128'(0));
            @(negedge clk);
        end
        pause_a = 1'b0;
        check_eq("overrun_clear", 128'(ovr_a), 128'(0));

        timing_frame(0, 11, 1'b1);
        check_eq("overrun_set", 128'(ovr_a), 128'(1));

        timing_frame(2, 37, 1'b0);
        check_eq("overrun_c_clear", 128'(ovr_c), 128'(0));

        @(negedge clk);
        tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("midframe_busy", 128'(busy_a), 128'(1));
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 128'(busy_a), 128'(0));
        check_eq("midrst_overrun", 128'(ovr_a), 128'(0));
        check_eq("midrst_pos_x", 128'(px_a), 128'({10'd200, 10'd140, 10'd80, 10'd20}));
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) model_reset(d);
        sb_a.delete();
        sb_b.delete();
        sb_c.delete();
        @(negedge clk);
        begin
            snap_t o, e;
            o = obs(0);
            e = model_snap(0);
            for (int f = 0; f < 6; f++) check_eq({"midrst_", fname[f]}, o[f], e[f]);
        end

        for (int f = 0; f < 150; f++) run_frame(0);
        for (int f = 0; f < 200; f++) run_frame(1);
        for (int f = 0; f < 120; f++) run_frame(2);

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) check_eq("sb_drained", 128'(sb_size(d)), 128'(0));
        cnt_d = 0;
        cnt_m = 0;
        for (int i = 0; i < 4; i++) begin
            if (hits_b[i*3 +: 3] == 3'd7) cnt_d++;
            if (mhit[1][i] == 7) cnt_m++;
        end
        check_eq("sat_count_b", 128'(cnt_d), 128'(cnt_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/box_physics_n.md
# box_physics_n

Parametrised N-box physics engine: the next generation of the four-box bouncing-sprite core. Each `frame_tick` starts a sequential per-frame update. Boxes are moved one per cycle with clamped wall reflection, then all unordered pairs are scanned one per cycle for overlap, cooldown-gated bounce, saturating hit counts and colour advance. It sits between the frame timing generator and the sprite renderer. Outputs are flat per-box buses that the renderer samples while `busy` is low.

## Interface
- `N`, 4: box count, 2..8; P = N(N-1)/2 pairs.
- `SCREEN_W`, 640: playfield width (px).
- `SCREEN_H`, 480: playfield height (px).
- `BOX_W`, 48: box width.
- `BOX_H`, 32: box height.
- `CD_FRAMES`, 5: per-pair cooldown reload, 1..15.
- `HIT_W`, 8: hit counter width.
- `COLOR_W`, 3: colour index width.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_tick` in 1: one-cycle frame strobe.
- `pause` in 1: while high, `frame_tick` in IDLE is ignored (not an overrun).
- `pos_x` out N*10: box i at `[i*10 +: 10]`.
- `pos_y` out N*9: box i at `[i*9 +: 9]`.
- `vel_x`, `vel_y` out N*8: signed, box i at `[i*8 +: 8]`.
- `hits` out N*HIT_W: saturating hit counts.
- `color_idx` out N*COLOR_W: colour indices.
- `busy` out 1: frame update in progress.
- `frame_done` out 1: one-cycle pulse at end of update.
- `overrun` out 1: sticky; a `frame_tick` arrived while `busy`.

## Operation
- **Reset values, box i:**
  - `pos_x` = 20+60i; `pos_y` = 20 (i even) or 60 (odd).
  - `vel_x` = +2 (even) or −2 (odd).
  - `vel_y` = −1 if i mod 4 ∈ {0,1}, else +1.
  - `hits` = 0; `color_idx` = i mod 2^COLOR_W.
  - All cooldowns 0; FSM IDLE; `busy`, `frame_done`, `overrun` = 0.
- **FSM: IDLE → MOVE → COLLIDE → DONE → IDLE.**
  - IDLE → MOVE on `frame_tick` & !`pause`.
  - MOVE: one box per cycle, i = 0..N−1. On its first cycle, also decrement every nonzero cooldown.
  - COLLIDE: one pair per cycle, lexicographic (0,1),(0,2)…(N−2,N−1).
  - DONE: one cycle, `frame_done`=1.
- **Move, per axis:**
  - Compute nx = pos+vel as 12-bit signed; MAX = SCREEN−BOX.
  - nx < 0 → pos = 0, vel = +|vel|.
  - nx > MAX → pos = MAX, vel = −|vel|.
  - Otherwise pos = nx, vel unchanged.
  - Positions never leave [0, MAX].
- **Overlap (i,j):** true iff all four hold, strict inequalities, on post-move positions: x_i < x_j+BOX_W, x_j < x_i+BOX_W, y_i < y_j+BOX_H, y_j < y_i+BOX_H.
- **Hit:** overlap and cd(i,j) = 0. Then:
  - Negate all four velocity components of i and j.
  - Increment `hits` of i and j, saturating at 2^HIT_W−1.
  - Increment `color_idx` of i and j, wrapping.
  - cd(i,j) = CD_FRAMES.
- **Overlap with cd ≠ 0:** no effect.
- **Serial semantics:** a box hit twice in one frame is negated twice, i.e. its velocity is restored. Each pair sees the effects of earlier pairs.
- **Cooldown effect:** a pair hit in frame f cannot re-hit before frame f+CD_FRAMES.
- **`frame_tick` while busy:** ignored, sets `overrun`; the in-progress frame is unaffected. Only reset clears `overrun`.
- **`pause` mid-frame:** no effect; the frame completes.
- **Reset mid-frame:** immediate return to reset values; partial updates are discarded.

## Timing
- Tick sampled in IDLE at cycle t:
  - `busy` = 1 for cycles t+1 .. t+N+P+1.
  - `frame_done` at t+N+P+1.
  - Earliest next accepted tick: t+N+P+2.
- Per-box outputs are registered and change only during MOVE/COLLIDE. They are stable whenever `busy` = 0.
- N = 4: latency 11 cycles.

## Structure
- **Package `box_physics_pkg`:**
  - Width constants: X_W=10, Y_W=9, V_W=8, CD_W=4.
  - FSM state enum.
  - Reset-value functions init_x(i), init_y(i), init_vx(i), init_vy(i).
  - Function pair_idx(i,j) mapping to a cooldown slot 0..P−1.
- **Sub-module `pair_sequencer`:** generates (i,j,slot,last) each cycle on `step`; restarts on `start`.
- The top level holds box register arrays, cooldown array and FSM.

## Test plan
- **Reset values:** reset, N=4 → `pos_x`={20,80,140,200}, `pos_y`={20,60,20,60}, `hits`=0, `color_idx`={0,1,2,3}; `busy`/`overrun`=0.
- **Wall clamp:** box 0 at x=1, vx=−3, one tick → x=0, vx=+3. Box at x=590, vx=+4 → x=592, vx=−4.
- **Single hit and cooldown:** boxes 0,1 overlapping, one tick → both velocities negated, `hits`=1, colours +1. Hold overlap → no further hit for the next 4 frames.
- **Saturation and wrap:** `hits`=255 and `color_idx`=7, hit → `hits` stays 255, `color_idx`=0.
- **Overrun and pause:** tick at t and t+3 (N=4) → `overrun`=1, single `frame_done` at t+11. `pause`=1 with a tick → no `busy`.
- **Double hit and parametrisation:** box 1 overlapping 0 and 2 → its velocity unchanged after frame, `hits`=2. N=8 → `frame_done` latency 37.
